// File: rtl/frac_lutk_ccff_tile_if.sv
// Bus bundle for the fracturable K-input LUT tile: configuration-chain controls
// and serial data, LUT select inputs, and all LUT/status outputs.
interface frac_lutk_ccff_tile_if #(
  parameter int K         = 6,
  parameter int MODE_BITS = 2
);
  logic                 config_enable;
  logic                 ccff_head;
  logic [K-1:0]         lut_in;
  logic                 ccff_tail;
  logic [3:0]           lutk2_out;
  logic [1:0]           lutk1_out;
  logic                 lutk_out;
  logic [MODE_BITS-1:0] mode_out;
  logic                 config_done;
  logic                 config_parity;

  // Driver side: the parent tile / configuration controller.
  modport master (
    output config_enable, ccff_head, lut_in,
    input  ccff_tail, lutk2_out, lutk1_out, lutk_out, mode_out,
           config_done, config_parity
  );

  // The LUT tile itself.
  modport slave (
    input  config_enable, ccff_head, lut_in,
    output ccff_tail, lutk2_out, lutk1_out, lutk_out, mode_out,
           config_done, config_parity
  );
endinterface

// File: rtl/frac_lutk_ccff_tile.sv
// Fracturable K-input LUT tile with its own configuration shift chain.
// The chain holds the 2**K truth table followed by MODE_BITS mode bits; a
// saturating bit counter raises config_done once a full image has been shifted,
// and a running parity tracks the XOR of everything currently stored.
// LUT outputs are combinational from lut_in and are held at 0 while the chain
// is shifting or not yet fully loaded, so downstream logic never sees a
// partially written table.
module frac_lutk_ccff_tile #(
  parameter int K         = 6,   // legal range 4..7
  parameter int MODE_BITS = 2    // >= 1
) (
  input logic                   prog_clock,
  input logic                   prog_reset_n,
  frac_lutk_ccff_tile_if.slave  bus
);

  localparam int SRAM_W = 2 ** K;
  localparam int LEN    = SRAM_W + MODE_BITS;
  localparam int CW     = $clog2(LEN + 1);

  localparam logic [CW-1:0] CNT_FULL   = CW'(LEN);
  localparam logic [CW-1:0] CNT_LAST   = CW'(LEN - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Running parity: the bit entering the chain joins, the bit leaving drops out.
  function automatic logic parity_update(input logic par, input logic in_bit,
                                         input logic out_bit);
    return par ^ in_bit ^ out_bit;
  endfunction

  logic [LEN-1:0]    mem_r;
  logic [CW-1:0]     cnt_r;
  logic              done_r;
  logic              parity_r;

  logic [SRAM_W-1:0] sram_s;
  logic [3:0]        lutk2_s;
  logic [1:0]        lutk1_s;
  logic              lutk_s;
  logic              gate_s;
  logic [K-1:0]      idx1_s;
  logic [K-1:0]      idx2_s;

  // Configuration chain, bit counter, done flag and running parity.
  always_ff @(posedge prog_clock) begin
    if (!prog_reset_n) begin
      mem_r    <= '0;
      cnt_r    <= '0;
      done_r   <= 1'b0;
      parity_r <= 1'b0;
    end else if (bus.config_enable) begin
      mem_r    <= {mem_r[LEN-2:0], bus.ccff_head};
      parity_r <= parity_update(parity_r, bus.ccff_head, mem_r[LEN-1]);
      if (cnt_r != CNT_FULL) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      // Done rises on the edge that completes the LEN-th shift and then sticks.
      done_r   <= done_r | (cnt_r == CNT_LAST);
    end else begin
      mem_r    <= mem_r;
      cnt_r    <= cnt_r;
      done_r   <= done_r;
      parity_r <= parity_r;
    end
  end

  assign sram_s = mem_r[SRAM_W-1:0];
  assign gate_s = bus.config_enable | ~done_r;

  // LUT evaluation: one K-input, two (K-1)-input and four (K-2)-input views of
  // the same table, all suppressed while the table is not trustworthy.
  always_comb begin
    lutk_s  = 1'b0;
    lutk1_s = 2'b00;
    lutk2_s = 4'b0000;
    idx1_s  = '0;
    idx2_s  = '0;
    if (gate_s) begin
      lutk_s  = 1'b0;
      lutk1_s = 2'b00;
      lutk2_s = 4'b0000;
    end else begin
      lutk_s = sram_s[bus.lut_in];
      for (int h = 0; h < 2; h++) begin
        idx1_s     = {h[0], bus.lut_in[K-2:0]};
        lutk1_s[h] = sram_s[idx1_s];
      end
      for (int q = 0; q < 4; q++) begin
        idx2_s     = {q[1:0], bus.lut_in[K-3:0]};
        lutk2_s[q] = sram_s[idx2_s];
      end
    end
  end

  assign bus.lutk_out      = lutk_s;
  assign bus.lutk1_out     = lutk1_s;
  assign bus.lutk2_out     = lutk2_s;
  assign bus.mode_out      = mem_r[LEN-1:SRAM_W];
  assign bus.ccff_tail     = mem_r[LEN-1];
  assign bus.config_done   = done_r;
  assign bus.config_parity = parity_r;

endmodule

// File: tb/tb_frac_lutk_ccff_tile.sv
// Bench for frac_lutk_ccff_tile: three tiles (K=4, 6, 7) share one stimulus
// stream. A shift-history model predicts every output of every tile on each
// cycle; directed hand-computed checks pin the model on the K=6 tile.
module tb_frac_lutk_ccff_tile;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       head;
  logic [6:0] lut;
  bit         chk_en;
  int         checks;
  int         failures;
  bit         hist[$];

  frac_lutk_ccff_tile_if #(.K(4), .MODE_BITS(2)) if4 ();
  frac_lutk_ccff_tile_if #(.K(6), .MODE_BITS(2)) if6 ();
  frac_lutk_ccff_tile_if #(.K(7), .MODE_BITS(2)) if7 ();

  assign if4.config_enable = en;
  assign if4.ccff_head     = head;
  assign if4.lut_in        = lut[3:0];
  assign if6.config_enable = en;
  assign if6.ccff_head     = head;
  assign if6.lut_in        = lut[5:0];
  assign if7.config_enable = en;
  assign if7.ccff_head     = head;
  assign if7.lut_in        = lut[6:0];

  frac_lutk_ccff_tile #(.K(4), .MODE_BITS(2)) dut4 (
    .prog_clock(clk), .prog_reset_n(rst_n), .bus(if4));
  frac_lutk_ccff_tile #(.K(6), .MODE_BITS(2)) dut6 (
    .prog_clock(clk), .prog_reset_n(rst_n), .bus(if6));
  frac_lutk_ccff_tile #(.K(7), .MODE_BITS(2)) dut7 (
    .prog_clock(clk), .prog_reset_n(rst_n), .bus(if7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the bits shifted in since the last reset, oldest first.
  always @(posedge clk) begin
    if (!rst_n) hist.delete();
    else if (en) hist.push_back(head);
  end

  // Stored chain bit i = the bit shifted in i shifts ago, or 0 if none.
  function automatic bit mem_bit(int i);
    if (i < hist.size()) return hist[hist.size() - 1 - i];
    return 1'b0;
  endfunction

  // Expected {tail, lutk2[3:0], lutk1[1:0], lutk, mode[1:0], done, parity}.
  function automatic logic [11:0] expect_vec(int k, int lut_v, bit en_v);
    int sw, len, lo;
    bit done, par, gate;
    logic [3:0] k2;
    logic [1:0] k1;
    logic       k0;
    sw   = 1 << k;
    len  = sw + 2;
    done = (hist.size() >= len);
    par  = 1'b0;
    for (int i = 0; i < len; i++) par ^= mem_bit(i);
    gate = en_v || !done;
    lo   = lut_v % sw;
    k0   = gate ? 1'b0 : mem_bit(lo);
    for (int h = 0; h < 2; h++)
      k1[h] = gate ? 1'b0 : mem_bit(h * (sw / 2) + (lut_v % (sw / 2)));
    for (int q = 0; q < 4; q++)
      k2[q] = gate ? 1'b0 : mem_bit(q * (sw / 4) + (lut_v % (sw / 4)));
    return {mem_bit(len - 1), k2, k1, k0, mem_bit(len - 1), mem_bit(len - 2),
            done, par};
  endfunction

  task automatic cmp(string nm, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic lit(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison of all three tiles against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_k4", {if4.ccff_tail, if4.lutk2_out, if4.lutk1_out, if4.lutk_out,
                       if4.mode_out, if4.config_done, if4.config_parity},
          expect_vec(4, int'(lut), en));
      cmp("model_k6", {if6.ccff_tail, if6.lutk2_out, if6.lutk1_out, if6.lutk_out,
                       if6.mode_out, if6.config_done, if6.config_parity},
          expect_vec(6, int'(lut), en));
      cmp("model_k7", {if7.ccff_tail, if7.lutk2_out, if7.lutk1_out, if7.lutk_out,
                       if7.mode_out, if7.config_done, if7.config_parity},
          expect_vec(7, int'(lut), en));
    end
  end

  task automatic shift(input bit b);
    en   = 1'b1;
    head = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [65:0] img;
  logic [69:0] pat;

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    head     = 1'b0;
    lut      = 7'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_reset();

    // 1: idle after reset
    lut = 7'h3F;
    idle(5);
    lit("rst_done",   {15'd0, if6.config_done},   16'd0);
    lit("rst_parity", {15'd0, if6.config_parity}, 16'd0);
    lit("rst_lut",    {9'd0, if6.ccff_tail, if6.lutk2_out, if6.lutk1_out, if6.lutk_out},
        16'd0);

    // 2: load a known image (mode MSB first, then table MSB..LSB)
    img = {2'b10, 64'hF0F0_0000_FFFF_AAAA};
    for (int i = 65; i >= 0; i--) begin
      shift(img[i]);
      if (i == 1) lit("done_early", {15'd0, if6.config_done}, 16'd0);
    end
    lit("done_66",   {15'd0, if6.config_done},   16'd1);
    lit("mode_10",   {14'd0, if6.mode_out},      16'd2);
    lit("parity_img",{15'd0, if6.config_parity}, 16'd1);
    en = 1'b0; lut = 7'd1; #1;
    lit("lutk_sel1", {15'd0, if6.lutk_out}, 16'd1);
    lut = 7'd0; #1;
    lit("lutk1_sel0", {14'd0, if6.lutk1_out}, 16'd0);
    lut = 7'd4; #1;
    lit("lutk2_sel4", {12'd0, if6.lutk2_out}, 16'h000A);
    for (int i = 0; i < 12; i++) begin
      lut = 7'(i * 11 + 3);
      idle(1);
    end

    // 3: marker walks through the chain
    do_reset();
    shift(1'b1);
    lit("par_entry", {15'd0, if6.config_parity}, 16'd1);
    for (int i = 2; i <= 66; i++) begin
      shift(1'b0);
      if (i == 65) lit("tail_65", {15'd0, if6.ccff_tail}, 16'd0);
    end
    lit("tail_66",   {15'd0, if6.ccff_tail},     16'd1);
    lit("par_inside",{15'd0, if6.config_parity}, 16'd1);
    shift(1'b0);
    lit("tail_67",   {15'd0, if6.ccff_tail},     16'd0);
    lit("par_exit",  {15'd0, if6.config_parity}, 16'd0);

    // 4: over-shift, tail forwards the first bits in order
    do_reset();
    for (int i = 0; i < 70; i++) pat[i] = 1'($urandom);
    pat[3:0] = 4'b1101;
    for (int i = 0; i < 70; i++) begin
      shift(pat[i]);
      if (i >= 65 && i <= 68)
        lit($sformatf("fwd_bit%0d", i - 65), {15'd0, if6.ccff_tail},
            {15'd0, pat[i - 65]});
    end
    lit("done_sat", {15'd0, if6.config_done}, 16'd1);
    idle(2);

    // 5: reset in the middle of a load, with enable still high
    do_reset();
    for (int i = 0; i < 30; i++) shift(1'b1);
    rst_n = 1'b0; en = 1'b1; head = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b0;
    lit("mid_parity", {15'd0, if6.config_parity}, 16'd0);
    lit("mid_mode",   {14'd0, if6.mode_out},      16'd0);
    for (int i = 1; i <= 66; i++) begin
      shift(1'(i % 3 == 0));
      if (i == 65) lit("reload_65", {15'd0, if6.config_done}, 16'd0);
    end
    lit("reload_66", {15'd0, if6.config_done}, 16'd1);

    // 6: glitch guard with an all-ones table
    do_reset();
    for (int i = 0; i < 130; i++) shift(1'b1);
    en = 1'b0; lut = 7'h55; #1;
    lit("ones_k4", {15'd0, if4.lutk_out}, 16'd1);
    lit("ones_k7", {15'd0, if7.lutk_out}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      shift(1'b1);
      lit("guard_k6", {9'd0, if6.lutk2_out, if6.lutk1_out, if6.lutk_out}, 16'd0);
    end
    en = 1'b0; #1;
    lit("release_k6", {9'd0, if6.lutk2_out, if6.lutk1_out, if6.lutk_out}, 16'h007F);
    idle(3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
